// File: rtl/uart_echo_pkg.sv
// Shared types for the UART echo engine: mode encodings, FSM states and the
// character transform applied on the way from the RX FIFO to the TX core.
package uart_echo_pkg;

  localparam int unsigned XFORM_W = 64;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_INC  = 2'd1,
    MODE_INV  = 2'd2,
    MODE_CASE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_e;

  // Works on a wide container; the caller truncates to its character width,
  // which also gives the modulo-2^DATA_W wrap for increment and invert.
  function automatic logic [XFORM_W-1:0] transform(input logic [XFORM_W-1:0] x,
                                                   input mode_e               mode,
                                                   input int unsigned         data_w);
    logic [XFORM_W-1:0] y;
    y = x;
    case (mode)
      MODE_INC:  y = x + XFORM_W'(1);
      MODE_INV:  y = ~x;
      MODE_CASE: if (data_w >= 6) y = x ^ XFORM_W'(32'h20);
      default:   y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/uart_echo_engine_if.sv
// Character handshake between the echo engine and the UART RX/TX cores.
interface uart_echo_engine_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_done;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_done;

  modport master (
    output rx_data, rx_done, tx_done,
    input  tx_data, tx_start
  );

  modport slave (
    input  rx_data, rx_done, tx_done,
    output tx_data, tx_start
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered level/full/empty and a combinational head.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_d;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head_c  = mem[rd_ptr];

  always_comb begin
    level_d = level + LVL_W'(do_push) - LVL_W'(do_pop);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_d;
      full  <= (level_d == LVL_W'(DEPTH));
      empty <= (level_d == '0);
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_echo_engine.sv
// Buffers received characters, transforms them and relaunches them on the TX
// core one at a time, with an optional idle gap after each frame.
module uart_echo_engine
  import uart_echo_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned GAP_CYCLES = 50000000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  uart_echo_engine_if.slave      uart,
  input  logic                   enable,
  input  logic [1:0]             mode,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       rx_count,
  output logic [CNT_W-1:0]       tx_count,
  output logic [CNT_W-1:0]       drop_count
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e              state_q, state_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q;
  logic [DATA_W-1:0]   head_c;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop_c;
  logic                push_c;
  logic                drop_c;

  assign push_c = uart.rx_done && (!fifo_full || pop_c);
  assign drop_c = uart.rx_done && fifo_full && !pop_c;

  assign uart.tx_data  = tx_data_q;
  assign uart.tx_start = tx_start_q;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (push_c),
    .push_data (uart.rx_data),
    .pop       (pop_c),
    .head_c    (head_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Next-state logic; mode is only looked at when a character is popped.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    tx_data_d = tx_data_q;
    pop_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) begin
          pop_c     = 1'b1;
          tx_data_d = DATA_W'(transform(XFORM_W'(head_c), mode_e'(mode), DATA_W));
          state_d   = START;
        end
      end
      START: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (uart.tx_done) begin
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
        else                                 gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overflow   <= 1'b0;
      rx_count   <= '0;
      tx_count   <= '0;
      drop_count <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= (state_d == START);
      overflow   <= overflow | drop_c;
      if (push_c)            rx_count   <= rx_count + CNT_W'(1);
      if (state_d == START)  tx_count   <= tx_count + CNT_W'(1);
      if (drop_c)            drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_echo_engine.sv
// Directed bench for uart_echo_engine with DEPTH=16 and a 4-cycle gap.
module tb_uart_echo_engine;
  import uart_echo_pkg::*;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned GAP    = 4;
  localparam int unsigned CNT_W  = 16;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              enable = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [4:0]        fifo_level;
  logic              overflow;
  logic [CNT_W-1:0]  rx_count, tx_count, drop_count;

  int checks = 0;
  int errors = 0;
  int exp_rx = 0;
  int exp_tx = 0;

  uart_echo_engine_if #(.DATA_W(DATA_W)) uart ();

  uart_echo_engine #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP),
    .CNT_W      (CNT_W)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .uart       (uart),
    .enable     (enable),
    .mode       (mode),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .rx_count   (rx_count),
    .tx_count   (tx_count),
    .drop_count (drop_count)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic rx_send(input logic [7:0] b);
    uart.rx_data = b;
    uart.rx_done = 1'b1;
    tick();
    uart.rx_done = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (uart.tx_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(uart.tx_start), 32'h1);
  endtask

  // Called in WAIT_DONE: end the frame and sit out the gap.
  task automatic complete_char();
    uart.tx_done = 1'b1;
    tick();
    uart.tx_done = 1'b0;
    repeat (GAP + 1) tick();
  endtask

  logic [7:0] v_in  [3] = '{8'hFF, 8'h5A, 8'h61};
  logic [1:0] v_md  [3] = '{2'd1, 2'd2, 2'd3};
  logic [7:0] v_exp [3] = '{8'h00, 8'hA5, 8'h41};

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;
    logic [7:0] exp_q [$];

    uart.rx_data = '0;
    uart.rx_done = 1'b0;
    uart.tx_done = 1'b0;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    check("rst_tx_start", 32'(uart.tx_start), 32'h0);
    check("rst_tx_data", 32'(uart.tx_data), 32'h0);
    check("rst_level", 32'(fifo_level), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_counts", 32'(rx_count) | 32'(tx_count) | 32'(drop_count), 32'h0);

    // Latency and gap with increment mode
    enable = 1'b1;
    mode   = 2'd1;
    rx_send(8'h41); exp_rx++;
    check("lat_level_n1", 32'(fifo_level), 32'h1);
    check("lat_start_n1", 32'(uart.tx_start), 32'h0);
    tick(); exp_tx++;
    check("lat_start_n2", 32'(uart.tx_start), 32'h1);
    check("lat_data", 32'(uart.tx_data), 32'h42);
    check("lat_tx_count", 32'(tx_count), 32'(exp_tx));
    tick();
    check("start_one_cycle", 32'(uart.tx_start), 32'h0);
    rx_send(8'h10); exp_rx++;
    check("wait_no_start", 32'(uart.tx_start), 32'h0);
    uart.tx_done = 1'b1;
    tick();
    uart.tx_done = 1'b0;
    n = 0;
    while (uart.tx_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    exp_tx++;
    check("gap_ticks", 32'(n), 32'd5);
    check("gap_next_data", 32'(uart.tx_data), 32'h11);
    tick();
    complete_char();

    // Transform table; mode changes after the pop must not affect tx_data
    for (int i = 0; i < 3; i++) begin
      mode = v_md[i];
      rx_send(v_in[i]); exp_rx++;
      tick(); exp_tx++;
      check($sformatf("xform_%0d", i), 32'(uart.tx_data), 32'(v_exp[i]));
      mode = 2'd0;
      tick();
      check($sformatf("xform_hold_%0d", i), 32'(uart.tx_data), 32'(v_exp[i]));
      complete_char();
    end

    // Fill with TX held, one drop on the 17th character
    enable = 1'b0;
    mode   = 2'd0;
    for (int i = 0; i < 17; i++) begin
      rx_send(8'(8'h30 + i));
      if (i < 16) begin
        exp_rx++;
        exp_q.push_back(8'(8'h30 + i));
      end
    end
    check("full_level", 32'(fifo_level), 32'd16);
    check("full_overflow", 32'(overflow), 32'h1);
    check("full_drops", 32'(drop_count), 32'h1);
    check("full_rx_count", 32'(rx_count), 32'(exp_rx));

    // Push and pop in the same cycle while full
    uart.rx_data = 8'h7E;
    uart.rx_done = 1'b1;
    enable = 1'b1;
    tick();
    uart.rx_done = 1'b0;
    exp_rx++;
    exp_q.push_back(8'h7E);
    check("pushpop_level", 32'(fifo_level), 32'd16);
    check("pushpop_drops", 32'(drop_count), 32'h1);
    check("pushpop_rx_count", 32'(rx_count), 32'(exp_rx));

    for (int k = 0; k < 17; k++) begin
      wait_start($sformatf("drain_start_%0d", k));
      exp_tx++;
      check($sformatf("drain_data_%0d", k), 32'(uart.tx_data), 32'(exp_q.pop_front()));
      tick();
      uart.tx_done = 1'b1;
      tick();
      uart.tx_done = 1'b0;
    end
    repeat (GAP + 2) tick();
    check("drain_level", 32'(fifo_level), 32'h0);
    check("drain_overflow_sticky", 32'(overflow), 32'h1);
    check("drain_tx_count", 32'(tx_count), 32'(exp_tx));

    // Enable dropped during WAIT_DONE
    rx_send(8'h55); exp_rx++;
    tick(); exp_tx++;
    check("en_start", 32'(uart.tx_start), 32'h1);
    tick();
    enable = 1'b0;
    rx_send(8'h56); exp_rx++;
    uart.tx_done = 1'b1;
    tick();
    uart.tx_done = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      if (uart.tx_start === 1'b1) seen = 1'b1;
      tick();
    end
    check("en_off_no_start", 32'(seen), 32'h0);
    check("en_off_level", 32'(fifo_level), 32'h1);
    check("en_off_hold_data", 32'(uart.tx_data), 32'h55);
    enable = 1'b1;
    wait_start("en_on_start");
    exp_tx++;
    check("en_on_data", 32'(uart.tx_data), 32'h56);
    tick();
    complete_char();
    check("en_rx_count", 32'(rx_count), 32'(exp_rx));
    check("en_tx_count", 32'(tx_count), 32'(exp_tx));

    // Reset in WAIT_DONE, then a stale tx_done
    rx_send(8'h01);
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    uart.tx_done = 1'b1;
    tick();
    uart.tx_done = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      if (uart.tx_start === 1'b1) seen = 1'b1;
      tick();
    end
    check("abort_no_start", 32'(seen), 32'h0);
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    check("abort_counts", 32'(rx_count) | 32'(tx_count) | 32'(drop_count), 32'h0);
    check("abort_level", 32'(fifo_level), 32'h0);
    check("abort_overflow", 32'(overflow), 32'h0);
    check("abort_tx_data", 32'(uart.tx_data), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_echo_engine.md
UART_ECHO_ENGINE -- requirements
Module: uart_echo_engine

Interface
REQ-001 Parameter DATA_W, default 8, character width in bits.
REQ-002 Parameter DEPTH, default 16, receive-FIFO entries; SHALL be a power of 2 and at least 2.
REQ-003 Parameter GAP_CYCLES, default 50000000, idle clocks inserted after each transmitted character; 0 means no gap.
REQ-004 Parameter CNT_W, default 16, width of the statistics counters.
REQ-005 Clock  in  1  single system clock; all logic on its rising edge.
REQ-006 Reset  in  1  reset, synchronous and active-high.
REQ-007 enable  in  1  1 = drain FIFO to TX; 0 = hold TX and keep buffering RX.
REQ-008 mode  in  2  transform: 0 pass, 1 increment, 2 invert, 3 case-toggle.
REQ-009 rx_data  in  DATA_W  received character from the UART RX core.
REQ-010 rx_done  in  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-011 tx_data  out  DATA_W  character for the UART TX core.
REQ-012 tx_start  out  1  one-cycle strobe that launches a transmission.
REQ-013 tx_done  in  1  one-cycle strobe from the TX core at the end of the frame.
REQ-014 fifo_level  out  $clog2(DEPTH)+1  current number of FIFO entries.
REQ-015 overflow  out  1  sticky flag, set when a character is dropped.
REQ-016 rx_count, tx_count, drop_count  out  CNT_W each  accepted, started and dropped characters.

Function
REQ-017 On rx_done, rx_data SHALL be pushed into the FIFO at the next edge if fifo_level<DEPTH.
REQ-018 If rx_done arrives while the FIFO is full and no pop occurs in the same cycle, the character SHALL be dropped, overflow SHALL be set and drop_count SHALL increment.
REQ-019 If a push and a pop occur in the same cycle with the FIFO full, both SHALL succeed and fifo_level SHALL be unchanged.
REQ-020 The FSM states SHALL be IDLE, START, WAIT_DONE and GAP.
REQ-021 IDLE->START when enable=1 and the FIFO is non-empty: pop the head and register tx_data=transform(head, mode) at the same edge.
REQ-022 In START, tx_start=1 for exactly one cycle and tx_count increments; START->WAIT_DONE unconditionally.
REQ-023 WAIT_DONE->GAP on tx_done, or WAIT_DONE->IDLE on tx_done when GAP_CYCLES=0.
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles, then go to IDLE.
REQ-025 A tx_done strobe outside WAIT_DONE SHALL be ignored.
REQ-026 Latency: with the FIFO empty, enable=1 and the FSM in IDLE, rx_done in cycle N SHALL produce tx_start high in cycle N+2.
REQ-027 tx_data SHALL hold its value from START until the next IDLE->START transition.
REQ-028 Transform, all results modulo 2^DATA_W:
  - mode 1: x+1, so 0xFF gives 0x00.
  - mode 2: ~x.
  - mode 3: x XOR 0x20 when DATA_W>=6, otherwise pass.
REQ-029 mode SHALL be sampled only at the IDLE->START edge.
REQ-030 When enable is deasserted mid-character, the current character and its gap SHALL complete; the FSM then stays in IDLE.
REQ-031 All counters SHALL wrap modulo 2^CNT_W.
REQ-032 Only Reset SHALL clear overflow.
REQ-033 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-034 While Reset=1, at the clock edge:
  - FSM goes to IDLE.
  - FIFO is emptied (fifo_level=0).
  - tx_data=0, tx_start=0, overflow=0.
  - All counters and the gap counter are cleared.
REQ-035 Reset asserted mid-transmission SHALL abort the transmission; a tx_done that arrives later SHALL be ignored.

Structure
REQ-036 Package uart_echo_pkg SHALL hold the mode encodings, the FSM state enum and the transform function.
REQ-037 The FIFO SHALL be a separate sub-module, sync_fifo, parametrised by DATA_W and DEPTH, with push, pop, full, empty and level ports.

Verification
REQ-038 GAP_CYCLES=4, mode=1: rx 0x41 -> tx_data=0x42, tx_start in cycle N+2; after tx_done, 4 idle cycles before the next start.
REQ-039 mode=1, rx 0xFF -> tx_data=0x00; mode=2, rx 0x5A -> 0xA5; mode=3, rx 0x61 -> 0x41.
REQ-040 enable=0, 17 rx strobes with DEPTH=16 -> fifo_level=16, overflow=1, drop_count=1; then enable=1 -> 16 characters are sent in order.
REQ-041 FIFO full, with rx_done and a pop in the same cycle -> no drop, fifo_level stays 16, rx_count increments.
REQ-042 Reset asserted in WAIT_DONE, then a late tx_done -> FSM in IDLE, tx_start remains 0, all counters 0.
REQ-043 enable dropped during WAIT_DONE -> that character completes and no further tx_start occurs until enable returns to 1.
